// File: rtl/bsg_dff_bank_pkg.sv
// rtl/bsg_dff_bank_pkg.sv - shared state encoding and default sizes for the write-arbitrated register bank
package bsg_dff_bank_pkg;

  typedef enum logic [0:0] {
    e_idle  = 1'b0,
    e_clear = 1'b1
  } state_e;

  localparam int width_default_lp   = 9;
  localparam int els_default_lp     = 4;
  localparam int num_req_default_lp = 3;

endpackage

// File: rtl/bsg_dff_bank_wr_arbiter_if.sv
// rtl/bsg_dff_bank_wr_arbiter_if.sv - requester, clear and read-bus signals of the bank write arbiter
interface bsg_dff_bank_wr_arbiter_if
  import bsg_dff_bank_pkg::*;
#(
  parameter int width_p   = width_default_lp,
  parameter int els_p     = els_default_lp,
  parameter int num_req_p = num_req_default_lp
);
  localparam int lg_els_lp = $clog2(els_p);

  logic [num_req_p-1:0]           v_i;
  logic [num_req_p*lg_els_lp-1:0] addr_i;
  logic [num_req_p*width_p-1:0]   data_i;
  logic [num_req_p-1:0]           yumi_o;
  logic                           clear_v_i;
  logic                           clear_ready_o;
  logic                           busy_o;
  logic [els_p*width_p-1:0]       data_o;

  modport master (
    output v_i, addr_i, data_i, clear_v_i,
    input  yumi_o, clear_ready_o, busy_o, data_o
  );

  modport slave (
    input  v_i, addr_i, data_i, clear_v_i,
    output yumi_o, clear_ready_o, busy_o, data_o
  );

endinterface

// File: rtl/bsg_rr_arb_ptr.sv
// rtl/bsg_rr_arb_ptr.sv - stateless round-robin pick starting just after the last grant
module bsg_rr_arb_ptr #(
  parameter int num_req_p = 3,
  localparam int lg_req_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] reqs_i,
  input  logic [lg_req_lp-1:0] last_i,
  input  logic                 en_i,
  output logic [num_req_p-1:0] grants_o,
  output logic [lg_req_lp-1:0] id_o
);

  always_comb begin
    int  idx;
    logic found;
    grants_o = '0;
    id_o     = '0;
    found    = 1'b0;
    idx      = 0;
    // Offsets 1..num_req_p visit every requester once, ending on last_i itself.
    for (int i = 1; i <= num_req_p; i++) begin
      idx = (int'(last_i) + i) % num_req_p;
      if (en_i && !found && reqs_i[idx]) begin
        found         = 1'b1;
        grants_o[idx] = 1'b1;
        id_o          = lg_req_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/bsg_dff_bank_wr_arbiter.sv
// rtl/bsg_dff_bank_wr_arbiter.sv - round-robin write arbiter and clear sequencer for a zero-reset register bank
module bsg_dff_bank_wr_arbiter
  import bsg_dff_bank_pkg::*;
#(
  parameter int width_p   = width_default_lp,
  parameter int els_p     = els_default_lp,
  parameter int num_req_p = num_req_default_lp
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  bsg_dff_bank_wr_arbiter_if.slave   bus
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int lg_req_lp = $clog2(num_req_p);

  state_e               state_q, state_d;
  logic [lg_els_lp-1:0] cnt_q, cnt_d;
  logic [lg_req_lp-1:0] last_q, last_d;

  logic                 arb_en;
  logic [num_req_p-1:0] grants;
  logic [lg_req_lp-1:0] grant_id;
  logic                 wr_v;
  logic [lg_els_lp-1:0] wr_addr;
  logic [width_p-1:0]   wr_data;
  logic                 clr_en;

  // Kept outside the FSM process so the grant feedback into last_d is not a combinational loop.
  assign arb_en = (state_q == e_idle) && !bus.clear_v_i;
  assign clr_en = (state_q == e_clear);

  bsg_rr_arb_ptr #(.num_req_p(num_req_p)) arb (
    .reqs_i   (bus.v_i),
    .last_i   (last_q),
    .en_i     (arb_en),
    .grants_o (grants),
    .id_o     (grant_id)
  );

  assign bus.yumi_o = grants;
  assign wr_v       = |grants;

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int r = 0; r < num_req_p; r++) begin
      if (grants[r]) begin
        wr_addr = bus.addr_i[r*lg_els_lp +: lg_els_lp];
        wr_data = bus.data_i[r*width_p +: width_p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      last_q  <= lg_req_lp'(num_req_p - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    last_d            = last_q;
    bus.clear_ready_o = 1'b0;
    bus.busy_o        = 1'b0;
    case (state_q)
      e_idle: begin
        bus.clear_ready_o = 1'b1;
        if (bus.clear_v_i) begin
          state_d = e_clear;
          cnt_d   = '0;
        end else if (wr_v) begin
          last_d = grant_id;
        end
      end
      e_clear: begin
        bus.busy_o = 1'b1;
        if (cnt_q == lg_els_lp'(els_p - 1)) begin
          state_d = e_idle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // Out-of-range write addresses match no entry, so such writes vanish here.
  for (genvar k = 0; k < els_p; k++) begin : g_ent
    logic               clr_hit;
    logic               wr_hit;
    logic [width_p-1:0] ent_q;

    assign clr_hit = clr_en && (cnt_q == lg_els_lp'(k));
    assign wr_hit  = wr_v && (wr_addr == lg_els_lp'(k));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        ent_q <= '0;
      end else if (clr_hit || wr_hit) begin
        ent_q <= clr_hit ? '0 : wr_data;
      end
    end

    assign bus.data_o[k*width_p +: width_p] = ent_q;
  end

endmodule

// File: tb/tb_bsg_dff_bank_wr_arbiter.sv
// tb/tb_bsg_dff_bank_wr_arbiter.sv - directed and randomized checks of the bank write arbiter
module tb_bsg_dff_bank_wr_arbiter;

  localparam int W = 9;
  localparam int E = 4;
  localparam int R = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bsg_dff_bank_wr_arbiter_if #(.width_p(W), .els_p(4), .num_req_p(R)) if4 ();
  bsg_dff_bank_wr_arbiter_if #(.width_p(W), .els_p(3), .num_req_p(R)) if3 ();

  bsg_dff_bank_wr_arbiter #(.width_p(W), .els_p(4), .num_req_p(R)) dut4 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (if4)
  );

  bsg_dff_bank_wr_arbiter #(.width_p(W), .els_p(3), .num_req_p(R)) dut3 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (if3)
  );

  function automatic logic [8:0] ent4(input int k);
    return if4.data_o[k*W +: W];
  endfunction

  task automatic drive4(input logic [2:0] v, input logic [1:0] a0, input logic [1:0] a1,
                        input logic [1:0] a2, input logic [8:0] d0, input logic [8:0] d1,
                        input logic [8:0] d2, input logic clr);
    if4.v_i       = v;
    if4.addr_i    = {a2, a1, a0};
    if4.data_i    = {d2, d1, d0};
    if4.clear_v_i = clr;
  endtask

  task automatic drive3(input logic [2:0] v, input logic [1:0] a0, input logic [1:0] a1,
                        input logic [1:0] a2, input logic [8:0] d0, input logic [8:0] d1,
                        input logic [8:0] d2);
    if3.v_i       = v;
    if3.addr_i    = {a2, a1, a0};
    if3.data_i    = {d2, d1, d0};
    if3.clear_v_i = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
    drive3(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
    drive3(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (if4.data_o !== 36'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", if4.data_o); end
    checks++; if (if4.yumi_o !== 3'b000) begin errors++; $display("FAIL reset_yumi got=%b exp=000", if4.yumi_o); end
    checks++; if (if4.clear_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", if4.clear_ready_o); end
    checks++; if (if4.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", if4.busy_o); end
    cyc();
    reset_n = 1'b1;
    drive4(3'b001, 2'd1, 2'd0, 2'd0, 9'h155, 9'h0, 9'h0, 1'b0);
    @(negedge clk);
    checks++; if (if4.yumi_o !== 3'b001) begin errors++; $display("FAIL reset_load_yumi got=%b exp=001", if4.yumi_o); end
    cyc();
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
    @(negedge clk);
    checks++; if (ent4(1) !== 9'h155) begin errors++; $display("FAIL reset_load_ent1 got=%h exp=155", ent4(1)); end
    reset_n = 1'b0;
    #1;
    checks++; if (if4.data_o !== 36'h0) begin errors++; $display("FAIL reset_async_data got=%h exp=0", if4.data_o); end
    checks++; if (if4.busy_o !== 1'b0 || if4.clear_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_async_hs got busy=%b ready=%b exp busy=0 ready=1", if4.busy_o, if4.clear_ready_o);
    end
    cyc();
    reset_n = 1'b1;
    drive4(3'b111, 2'd0, 2'd0, 2'd0, 9'h1, 9'h2, 9'h3, 1'b0);
    @(negedge clk);
    checks++; if (if4.yumi_o !== 3'b001) begin errors++; $display("FAIL reset_first_grant got=%b exp=001", if4.yumi_o); end
    cyc();
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_y [4];
    exp_y[0] = 3'b001; exp_y[1] = 3'b010; exp_y[2] = 3'b100; exp_y[3] = 3'b001;
    do_reset();
    drive4(3'b111, 2'd2, 2'd2, 2'd2, 9'h011, 9'h022, 9'h033, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (if4.yumi_o !== exp_y[i]) begin errors++; $display("FAIL rr_yumi[%0d] got=%b exp=%b", i, if4.yumi_o, exp_y[i]); end
      if (i == 3) begin
        checks++; if (ent4(2) !== 9'h033) begin errors++; $display("FAIL rr_ent2 got=%h exp=033", ent4(2)); end
      end
      cyc();
    end
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
    @(negedge clk);
    checks++; if (ent4(2) !== 9'h011) begin errors++; $display("FAIL rr_ent2_final got=%h exp=011", ent4(2)); end
  endtask

  task automatic test_single_requester();
    logic [35:0] exp_bus;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive4(3'b010, 2'd0, 2'(k), 2'd0, 9'h0, 9'(9'h1FF - k), 9'h0, 1'b0);
      @(negedge clk);
      checks++; if (if4.yumi_o !== 3'b010) begin errors++; $display("FAIL single_yumi[%0d] got=%b exp=010", k, if4.yumi_o); end
      cyc();
    end
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
    exp_bus = {9'h1FC, 9'h1FD, 9'h1FE, 9'h1FF};
    @(negedge clk);
    checks++; if (if4.data_o !== exp_bus) begin errors++; $display("FAIL single_data got=%h exp=%h", if4.data_o, exp_bus); end
  endtask

  task automatic test_clear_priority();
    int n;
    bit done;
    do_reset();
    drive4(3'b001, 2'd3, 2'd0, 2'd0, 9'h1A5, 9'h0, 9'h0, 1'b0);
    cyc();
    drive4(3'b001, 2'd0, 2'd0, 2'd0, 9'h0F0, 9'h0, 9'h0, 1'b1);
    @(negedge clk);
    checks++; if (if4.yumi_o !== 3'b000) begin errors++; $display("FAIL clrpri_yumi got=%b exp=000", if4.yumi_o); end
    checks++; if (if4.clear_ready_o !== 1'b1) begin errors++; $display("FAIL clrpri_ready got=%b exp=1", if4.clear_ready_o); end
    cyc();
    if4.clear_v_i = 1'b0;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (if4.busy_o === 1'b1) begin
        n++;
        checks++; if (if4.yumi_o !== 3'b000 || if4.clear_ready_o !== 1'b0) begin
          errors++; $display("FAIL clrpri_sweep_hs got yumi=%b ready=%b exp yumi=000 ready=0", if4.yumi_o, if4.clear_ready_o);
        end
        cyc();
      end else begin
        done = 1'b1;
        checks++; if (if4.yumi_o !== 3'b001) begin errors++; $display("FAIL clrpri_post_grant got=%b exp=001", if4.yumi_o); end
        checks++; if (if4.data_o !== 36'h0) begin errors++; $display("FAIL clrpri_zero got=%h exp=0", if4.data_o); end
      end
    end
    checks++; if (!done || n != E) begin errors++; $display("FAIL clrpri_busy_len got=%0d done=%0d exp=%0d", n, done, E); end
    cyc();
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
    @(negedge clk);
    checks++; if (ent4(0) !== 9'h0F0) begin errors++; $display("FAIL clrpri_post_write got=%h exp=0f0", ent4(0)); end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    drive4(3'b001, 2'd3, 2'd0, 2'd0, 9'h013, 9'h0, 9'h0, 1'b0);
    cyc();
    drive4(3'b010, 2'd0, 2'd2, 2'd0, 9'h0, 9'h024, 9'h0, 1'b0);
    cyc();
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b1);
    cyc();
    if4.clear_v_i = 1'b0;
    cyc();
    @(negedge clk);
    checks++; if (if4.busy_o !== 1'b1) begin errors++; $display("FAIL midclr_busy got=%b exp=1", if4.busy_o); end
    checks++; if (ent4(3) !== 9'h013 || ent4(2) !== 9'h024) begin
      errors++; $display("FAIL midclr_pre got e3=%h e2=%h exp e3=013 e2=024", ent4(3), ent4(2));
    end
    reset_n = 1'b0;
    #1;
    checks++; if (if4.data_o !== 36'h0) begin errors++; $display("FAIL midclr_data got=%h exp=0", if4.data_o); end
    checks++; if (if4.busy_o !== 1'b0 || if4.clear_ready_o !== 1'b1) begin
      errors++; $display("FAIL midclr_hs got busy=%b ready=%b exp busy=0 ready=1", if4.busy_o, if4.clear_ready_o);
    end
    cyc();
    reset_n = 1'b1;
    drive4(3'b100, 2'd0, 2'd0, 2'd1, 9'h0, 9'h0, 9'h055, 1'b0);
    @(negedge clk);
    checks++; if (if4.yumi_o !== 3'b100 || if4.busy_o !== 1'b0) begin
      errors++; $display("FAIL midclr_idle got yumi=%b busy=%b exp yumi=100 busy=0", if4.yumi_o, if4.busy_o);
    end
    cyc();
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
  endtask

  task automatic test_bad_address();
    logic [26:0] exp_bus;
    do_reset();
    drive3(3'b100, 2'd0, 2'd0, 2'd1, 9'h0, 9'h0, 9'h077);
    @(negedge clk);
    checks++; if (if3.yumi_o !== 3'b100) begin errors++; $display("FAIL badaddr_setup got=%b exp=100", if3.yumi_o); end
    cyc();
    drive3(3'b001, 2'd3, 2'd0, 2'd0, 9'h0AA, 9'h0, 9'h0);
    @(negedge clk);
    checks++; if (if3.yumi_o !== 3'b001) begin errors++; $display("FAIL badaddr_yumi got=%b exp=001", if3.yumi_o); end
    cyc();
    drive3(3'b111, 2'd0, 2'd0, 2'd0, 9'h1, 9'h2, 9'h3);
    exp_bus = 27'h077 << 9;
    @(negedge clk);
    checks++; if (if3.data_o !== exp_bus) begin errors++; $display("FAIL badaddr_data got=%h exp=%h", if3.data_o, exp_bus); end
    checks++; if (if3.yumi_o !== 3'b010) begin errors++; $display("FAIL badaddr_next got=%b exp=010", if3.yumi_o); end
    cyc();
    drive3(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0);
  endtask

  task automatic test_random();
    logic [8:0]  mem_m [E];
    int          last_m;
    int          sweep_m;
    bit          pend [R];
    logic [1:0]  pa [R];
    logic [8:0]  pd [R];
    logic [2:0]  v;
    logic        clr;
    int          g;
    logic [2:0]  exp_y;
    logic [35:0] exp_bus;
    do_reset();
    for (int k = 0; k < E; k++) mem_m[k] = '0;
    for (int r = 0; r < R; r++) begin pend[r] = 1'b0; pa[r] = '0; pd[r] = '0; end
    last_m  = R - 1;
    sweep_m = 0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < R; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1;
          pa[r]   = 2'($urandom_range(0, 3));
          pd[r]   = 9'($urandom_range(0, 511));
        end
      end
      v   = {pend[2], pend[1], pend[0]};
      clr = ($urandom_range(0, 15) == 0);
      drive4(v, pa[0], pa[1], pa[2], pd[0], pd[1], pd[2], clr);
      g = -1;
      if (sweep_m == 0 && !clr) begin
        for (int i = 1; i <= R; i++) begin
          if (g < 0 && pend[(last_m + i) % R]) g = (last_m + i) % R;
        end
      end
      exp_y   = (g >= 0) ? 3'(1 << g) : 3'b000;
      exp_bus = {mem_m[3], mem_m[2], mem_m[1], mem_m[0]};
      @(negedge clk);
      checks++; if (if4.yumi_o !== exp_y) begin errors++; $display("FAIL rand_yumi n=%0d got=%b exp=%b", n, if4.yumi_o, exp_y); end
      checks++; if (if4.busy_o !== (sweep_m != 0)) begin errors++; $display("FAIL rand_busy n=%0d got=%b exp=%0d", n, if4.busy_o, sweep_m != 0); end
      checks++; if (if4.clear_ready_o !== (sweep_m == 0)) begin errors++; $display("FAIL rand_ready n=%0d got=%b exp=%0d", n, if4.clear_ready_o, sweep_m == 0); end
      checks++; if (if4.data_o !== exp_bus) begin errors++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, if4.data_o, exp_bus); end
      if (sweep_m > 0) begin
        mem_m[E - sweep_m] = '0;
        sweep_m--;
      end else if (clr) begin
        sweep_m = E;
      end else if (g >= 0) begin
        mem_m[pa[g]] = pd[g];
        last_m  = g;
        pend[g] = 1'b0;
      end
      cyc();
    end
    drive4(3'b000, 2'd0, 2'd0, 2'd0, 9'h0, 9'h0, 9'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_requester();
    test_clear_priority();
    test_reset_mid_clear();
    test_bad_address();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
